cache_hier_ctrl: RTL and testbench
==================================

Name: cache_hier_ctrl

Overview:
- Parametrised three-level (L1 → L2 → main memory) access sequencer. Successor to the fixed two-cache controller.
- Accepts one request at a time through a valid/ready handshake.
- Walks the hierarchy using per-level fixed latencies. Returns read data with a source tag.
- Performs write-through on writes and allocate-on-read-miss fills.
- Sits between the core-side request port and the l1, l2 and mem storage modules.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- L1_LAT, 3, L1 access latency in cycles, ≥1.
- L2_LAT, 3, L2 access latency in cycles, ≥1.
- MEM_LAT, 5, memory access latency in cycles, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  single-cycle response pulse
- resp_rdata  out  DATA_W  read data, or echoed write data
- resp_src  out  2  00 L1, 01 L2, 10 MEM, 11 write-ack
- l1_rd_en, l1_wr_en  out  1  L1 access strobes
- l1_addr  out  ADDR_W  L1 address
- l1_wdata  out  DATA_W  L1 write data
- l1_rdata  in  DATA_W  L1 read data
- l1_hit  in  1  L1 hit
- l2_rd_en, l2_wr_en, l2_addr, l2_wdata, l2_rdata, l2_hit: same as L1, for L2.
- mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_rdata: same as L1, for memory (no hit signal).

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. FSM state = IDLE. Counters = 0.
- Timing notation: edge 0 is the edge on which req_valid & req_ready is sampled high. "Cycle n" is the cycle after edge n.
- Request capture: address, data and op are registered at edge 0. Level address/data outputs drive from these registers.
- req_ready is high only in IDLE. req_valid while busy is ignored; the master holds it.
- FSM states: IDLE, L1_RD, L2_RD, MEM_RD, WR, FILL.
- Read flow:
  - L1_RD: l1_rd_en high for cycles 0..L1_LAT-1. l1_hit and l1_rdata are sampled at edge L1_LAT.
  - On L1 hit: resp_valid, resp_src=00 and resp_rdata=l1_rdata in cycle L1_LAT. Go to IDLE.
  - On L1 miss: L2_RD, l2_rd_en high for L2_LAT cycles.
  - On L2 hit: response in cycle L1_LAT+L2_LAT with src=01, then FILL.
  - On L2 miss: MEM_RD for MEM_LAT cycles, then response in cycle L1_LAT+L2_LAT+MEM_LAT with src=10, then FILL.
- FILL: starts in the response cycle.
  - After an L2 hit: l1_wr_en high for L1_LAT cycles.
  - After a memory read: l1_wr_en and l2_wr_en both rise together, each held for its own LAT, and FILL lasts max of the two.
  - Fill data is the returned word. Go to IDLE after FILL.
- WR (write-through):
  - l1_wr_en, l2_wr_en and mem_wr_en rise together in cycle 0. Each is held for its own LAT cycles.
  - resp_valid with src=11 and resp_rdata=wdata in cycle max(L1_LAT, L2_LAT, MEM_LAT). Go to IDLE.
- Back-to-back: when the next state is IDLE, req_ready is high in the resp_valid cycle. A request accepted there starts immediately.
- Counter: a single down/up counter sized $clog2(max LAT + 1). All latencies are exact; there is no early termination.
- Reset mid-operation: all strobes drop immediately. The in-flight request is discarded with no response. FSM returns to IDLE.
- Hit/miss inputs are sampled only at the final access edge. Values at other times are don't-care.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_l1_hit, perf_l2_hit, perf_mem_rd and perf_wr, each 32 bits.
  - Each counter increments on the corresponding response pulse and saturates at 0xFFFF_FFFF.
  - Counters clear on rst.
- When undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - ctrl_state_e enum.
  - resp_src_e enum (SRC_L1, SRC_L2, SRC_MEM, SRC_WACK).
  - max3 constant function for latency sizing.
- One sub-module, lat_strobe: a loadable strobe-with-count that holds an enable for N cycles and flags done.
  - Instantiated per level for the fill and write phases.

Test Plan:
All tests use defaults (3/3/5).
1. Write 0xDEADBEEF to 0x40 → all three wr_en high in cycle 0. l1/l2 wr_en drop after cycle 2, mem_wr_en after cycle 4. resp_valid in cycle 5 with src=11 and rdata=0xDEADBEEF.
2. Read 0x40 with l1_hit=1, l1_rdata=0xDEADBEEF → resp_valid in cycle 3, src=00. req_ready high in cycle 3. A second request accepted at edge 3 gets l1_rd_en in cycle 3.
3. Read 0x80 with L1 miss, L2 hit, l2_rdata=0x12345678 → resp in cycle 6 with src=01. l1_wr_en high in cycles 6–8 with wdata 0x12345678. req_ready returns in cycle 9.
4. Read 0xC0 with both caches missing, mem_rdata=0xCAFEF00D → resp in cycle 11 with src=10. l1/l2 wr_en high in cycles 11–13. req_ready returns in cycle 14.
5. rst asserted in cycle 8 of test 4 → mem_rd_en falls asynchronously. No resp_valid. req_ready=1 after reset release.
6. req_valid held high during test 3's FILL → not accepted until cycle 9. Accepted exactly once.

Source files
------------

// File: rtl/cache_hier_ctrl_pkg.sv
// Shared types and helpers for the three-level cache access sequencer.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L1_RD,
        L2_RD,
        MEM_RD,
        WR,
        FILL
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SRC_L1   = 2'b00,
        SRC_L2   = 2'b01,
        SRC_MEM  = 2'b10,
        SRC_WACK = 2'b11
    } resp_src_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cache_hier_ctrl_if.sv
// Core request/response port plus L1, L2 and memory storage ports.
// master = core and storage side, slave = the sequencer.
interface cache_hier_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [1:0]        resp_src;

    logic              l1_rd_en;
    logic              l1_wr_en;
    logic [ADDR_W-1:0] l1_addr;
    logic [DATA_W-1:0] l1_wdata;
    logic [DATA_W-1:0] l1_rdata;
    logic              l1_hit;

    logic              l2_rd_en;
    logic              l2_wr_en;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_wdata;
    logic [DATA_W-1:0] l2_rdata;
    logic              l2_hit;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_src,
        input  l1_rd_en, l1_wr_en, l1_addr, l1_wdata,
        output l1_rdata, l1_hit,
        input  l2_rd_en, l2_wr_en, l2_addr, l2_wdata,
        output l2_rdata, l2_hit,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_src,
        output l1_rd_en, l1_wr_en, l1_addr, l1_wdata,
        input  l1_rdata, l1_hit,
        output l2_rd_en, l2_wr_en, l2_addr, l2_wdata,
        input  l2_rdata, l2_hit,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/cache_hier_ctrl_lat_strobe.sv
// Loadable strobe: o_en stays high for i_len cycles after a load; o_done
// marks the last of those cycles.
module lat_strobe #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_len,
    output logic          o_en,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_en   = (r_cnt != '0);
    assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/cache_hier_ctrl.sv
// Three-level (L1 -> L2 -> memory) access sequencer with fixed per-level latencies.
// Optional perf counters are built when CACHE_PERF_CNT_EN is defined.
module cache_hier_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned L1_LAT  = 3,
    parameter int unsigned L2_LAT  = 3,
    parameter int unsigned MEM_LAT = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]       perf_l1_hit,
    output logic [31:0]       perf_l2_hit,
    output logic [31:0]       perf_mem_rd,
    output logic [31:0]       perf_wr,
`endif
    cache_hier_ctrl_if.slave  bus
);

    localparam int unsigned MAX_LAT = max3(L1_LAT, L2_LAT, MEM_LAT);
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] L1_LEN  = CW'(L1_LAT);
    localparam logic [CW-1:0] L2_LEN  = CW'(L2_LAT);
    localparam logic [CW-1:0] MEM_LEN = CW'(MEM_LAT);

    ctrl_state_e       r_state, w_next;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data, w_data_nx;
    logic              r_resp_valid, w_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata;
    resp_src_e         r_resp_src, w_resp_src;
    logic              w_capture;
    logic              w_last;
    logic              w_ld_l1, w_ld_l2, w_ld_mem;
    logic              w_l1_en, w_l2_en, w_mem_en;
    logic              w_l1_done, w_l2_done, w_mem_done;
    logic              w_stb_last;

    lat_strobe #(.CW(CW)) u_l1_stb (
        .clk(clk), .rst(rst), .i_load(w_ld_l1), .i_len(L1_LEN),
        .o_en(w_l1_en), .o_done(w_l1_done)
    );

    lat_strobe #(.CW(CW)) u_l2_stb (
        .clk(clk), .rst(rst), .i_load(w_ld_l2), .i_len(L2_LEN),
        .o_en(w_l2_en), .o_done(w_l2_done)
    );

    lat_strobe #(.CW(CW)) u_mem_stb (
        .clk(clk), .rst(rst), .i_load(w_ld_mem), .i_len(MEM_LEN),
        .o_en(w_mem_en), .o_done(w_mem_done)
    );

    assign w_last = (r_cnt == '0);
    // WR and FILL end once every running strobe is in its final cycle.
    assign w_stb_last = (!w_l1_en || w_l1_done) &&
                        (!w_l2_en || w_l2_done) &&
                        (!w_mem_en || w_mem_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_src   <= SRC_L1;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_nx;
            r_data       <= w_data_nx;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_src   <= w_resp_src;
            if (w_capture) begin
                r_addr <= bus.req_addr;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_nx     = w_last ? r_cnt : r_cnt - CW'(1);
        w_data_nx    = r_data;
        w_capture    = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_rdata = r_resp_rdata;
        w_resp_src   = r_resp_src;
        w_ld_l1      = 1'b0;
        w_ld_l2      = 1'b0;
        w_ld_mem     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_capture = 1'b1;
                    w_data_nx = bus.req_wdata;
                    if (bus.req_wr) begin
                        w_next   = WR;
                        w_ld_l1  = 1'b1;
                        w_ld_l2  = 1'b1;
                        w_ld_mem = 1'b1;
                    end else begin
                        w_next   = L1_RD;
                        w_cnt_nx = CW'(L1_LAT - 1);
                    end
                end
            end
            L1_RD: begin
                if (w_last) begin
                    if (bus.l1_hit) begin
                        w_next       = IDLE;
                        w_resp_valid = 1'b1;
                        w_resp_rdata = bus.l1_rdata;
                        w_resp_src   = SRC_L1;
                    end else begin
                        w_next   = L2_RD;
                        w_cnt_nx = CW'(L2_LAT - 1);
                    end
                end
            end
            L2_RD: begin
                if (w_last) begin
                    if (bus.l2_hit) begin
                        w_next       = FILL;
                        w_resp_valid = 1'b1;
                        w_resp_rdata = bus.l2_rdata;
                        w_resp_src   = SRC_L2;
                        w_data_nx    = bus.l2_rdata;
                        w_ld_l1      = 1'b1;
                    end else begin
                        w_next   = MEM_RD;
                        w_cnt_nx = CW'(MEM_LAT - 1);
                    end
                end
            end
            MEM_RD: begin
                if (w_last) begin
                    w_next       = FILL;
                    w_resp_valid = 1'b1;
                    w_resp_rdata = bus.mem_rdata;
                    w_resp_src   = SRC_MEM;
                    w_data_nx    = bus.mem_rdata;
                    w_ld_l1      = 1'b1;
                    w_ld_l2      = 1'b1;
                end
            end
            WR: begin
                if (w_stb_last) begin
                    w_next       = IDLE;
                    w_resp_valid = 1'b1;
                    w_resp_rdata = r_data;
                    w_resp_src   = SRC_WACK;
                end
            end
            FILL: begin
                if (w_stb_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_src   = r_resp_src;

    assign bus.l1_rd_en  = (r_state == L1_RD);
    assign bus.l2_rd_en  = (r_state == L2_RD);
    assign bus.mem_rd_en = (r_state == MEM_RD);
    assign bus.l1_wr_en  = w_l1_en;
    assign bus.l2_wr_en  = w_l2_en;
    assign bus.mem_wr_en = w_mem_en;

    assign bus.l1_addr   = r_addr;
    assign bus.l2_addr   = r_addr;
    assign bus.mem_addr  = r_addr;
    assign bus.l1_wdata  = r_data;
    assign bus.l2_wdata  = r_data;
    assign bus.mem_wdata = r_data;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] r_perf_l1, r_perf_l2, r_perf_mem, r_perf_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_l1  <= '0;
            r_perf_l2  <= '0;
            r_perf_mem <= '0;
            r_perf_wr  <= '0;
        end else if (r_resp_valid) begin
            unique case (r_resp_src)
                SRC_L1:   if (r_perf_l1  != '1) r_perf_l1  <= r_perf_l1  + 32'd1;
                SRC_L2:   if (r_perf_l2  != '1) r_perf_l2  <= r_perf_l2  + 32'd1;
                SRC_MEM:  if (r_perf_mem != '1) r_perf_mem <= r_perf_mem + 32'd1;
                SRC_WACK: if (r_perf_wr  != '1) r_perf_wr  <= r_perf_wr  + 32'd1;
            endcase
        end
    end

    assign perf_l1_hit = r_perf_l1;
    assign perf_l2_hit = r_perf_l2;
    assign perf_mem_rd = r_perf_mem;
    assign perf_wr     = r_perf_wr;
`endif

endmodule

// File: tb/tb_cache_hier_ctrl.sv
// Directed scoreboard bench for cache_hier_ctrl at default latencies 3/3/5.
module tb_cache_hier_ctrl;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    cache_hier_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] perf_l1_hit, perf_l2_hit, perf_mem_rd, perf_wr;
`endif

    cache_hier_ctrl #(
        .ADDR_W(32), .DATA_W(32), .L1_LAT(3), .L2_LAT(3), .MEM_LAT(5)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef CACHE_PERF_CNT_EN
        .perf_l1_hit(perf_l1_hit),
        .perf_l2_hit(perf_l2_hit),
        .perf_mem_rd(perf_mem_rd),
        .perf_wr(perf_wr),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [31:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        sb.push_back(e);
    endtask

    // One clock: land #1 after the edge and retire any response against the scoreboard.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_src", 32'(bus.resp_src), 32'(e.src));
                chk("resp_rdata", bus.resp_rdata, e.data);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Present a request for one edge; returns in cycle 0 of that request.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        cyc();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.l1_rdata  = '0;
        bus.l1_hit    = 1'b0;
        bus.l2_rdata  = '0;
        bus.l2_hit    = 1'b0;
        bus.mem_rdata = '0;

        run(2);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_src", 32'(bus.resp_src), 32'd0);
        chk("rst_strobes", 32'({bus.l1_rd_en, bus.l1_wr_en, bus.l2_rd_en, bus.l2_wr_en,
                                bus.mem_rd_en, bus.mem_wr_en}), 32'd0);
        chk("rst_addr", bus.l1_addr, 32'd0);
        rst = 1'b0;
        run(1);

        // Write-through
        push(2'b11, 32'hDEADBEEF);
        issue(1'b1, 32'h40, 32'hDEADBEEF);
        chk("wr_c0_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en, bus.mem_wr_en}), 32'h7);
        chk("wr_c0_ready", 32'(bus.req_ready), 32'd0);
        chk("wr_c0_mem_addr", bus.mem_addr, 32'h40);
        chk("wr_c0_l2_wdata", bus.l2_wdata, 32'hDEADBEEF);
        run(2);
        chk("wr_c2_l1l2_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en}), 32'h3);
        run(1);
        chk("wr_c3_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en, bus.mem_wr_en}), 32'h1);
        run(1);
        chk("wr_c4_mem_wr_en", 32'(bus.mem_wr_en), 32'd1);
        chk("wr_c4_resp_valid", 32'(bus.resp_valid), 32'd0);
        run(1);
        chk("wr_c5_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("wr_c5_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("wr_c5_ready", 32'(bus.req_ready), 32'd1);

        // L1 hit, then a back-to-back request in the response cycle
        bus.l1_hit   = 1'b1;
        bus.l1_rdata = 32'hDEADBEEF;
        push(2'b00, 32'hDEADBEEF);
        issue(1'b0, 32'h40, 32'h0);
        chk("l1_c0_rd_en", 32'(bus.l1_rd_en), 32'd1);
        chk("l1_c0_addr", bus.l1_addr, 32'h40);
        chk("l1_c0_ready", 32'(bus.req_ready), 32'd0);
        run(2);
        chk("l1_c2_rd_en", 32'(bus.l1_rd_en), 32'd1);
        run(1);
        chk("l1_c3_rd_en", 32'(bus.l1_rd_en), 32'd0);
        chk("l1_c3_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("l1_c3_ready", 32'(bus.req_ready), 32'd1);
        bus.l1_rdata = 32'h11112222;
        push(2'b00, 32'h11112222);
        issue(1'b0, 32'h44, 32'h0);
        chk("b2b_c0_rd_en", 32'(bus.l1_rd_en), 32'd1);
        chk("b2b_c0_addr", bus.l1_addr, 32'h44);
        chk("b2b_c0_resp_valid", 32'(bus.resp_valid), 32'd0);
        run(3);
        chk("b2b_c3_resp_valid", 32'(bus.resp_valid), 32'd1);

        // L1 miss, L2 hit, L1 fill; a write is held on req_valid during the fill
        bus.l1_hit   = 1'b0;
        bus.l2_hit   = 1'b1;
        bus.l2_rdata = 32'h12345678;
        push(2'b01, 32'h12345678);
        issue(1'b0, 32'h80, 32'h0);
        chk("l2_c0_rd_en", 32'({bus.l1_rd_en, bus.l2_rd_en}), 32'h2);
        run(3);
        chk("l2_c3_rd_en", 32'({bus.l1_rd_en, bus.l2_rd_en}), 32'h1);
        chk("l2_c3_addr", bus.l2_addr, 32'h80);
        run(2);
        chk("l2_c5_rd_en", 32'(bus.l2_rd_en), 32'd1);
        chk("l2_c5_resp_valid", 32'(bus.resp_valid), 32'd0);
        run(1);
        chk("l2_c6_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("l2_c6_l2_rd_en", 32'(bus.l2_rd_en), 32'd0);
        chk("l2_c6_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en, bus.mem_wr_en}), 32'h4);
        chk("l2_c6_l1_wdata", bus.l1_wdata, 32'h12345678);
        chk("l2_c6_l1_addr", bus.l1_addr, 32'h80);
        chk("l2_c6_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h100;
        bus.req_wdata = 32'hA5A5A5A5;
        push(2'b11, 32'hA5A5A5A5);
        run(1);
        chk("fill_c7_ready", 32'(bus.req_ready), 32'd0);
        chk("fill_c7_wr_en", 32'({bus.l1_wr_en, bus.mem_wr_en}), 32'h2);
        run(1);
        chk("fill_c8_l1_wr_en", 32'(bus.l1_wr_en), 32'd1);
        chk("fill_c8_ready", 32'(bus.req_ready), 32'd0);
        run(1);
        chk("fill_c9_wr_en", 32'({bus.l1_wr_en, bus.mem_wr_en}), 32'h0);
        chk("fill_c9_ready", 32'(bus.req_ready), 32'd1);
        run(1);
        bus.req_valid = 1'b0;
        chk("held_c0_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en, bus.mem_wr_en}), 32'h7);
        chk("held_c0_ready", 32'(bus.req_ready), 32'd0);
        chk("held_c0_wdata", bus.l1_wdata, 32'hA5A5A5A5);
        chk("held_c0_addr", bus.mem_addr, 32'h100);
        run(5);
        chk("held_c5_resp_valid", 32'(bus.resp_valid), 32'd1);
        run(2);
        chk("held_once_idle", 32'({bus.resp_valid, bus.mem_wr_en, bus.req_ready}), 32'h1);

        // Both caches miss, memory read, L1+L2 fill
        bus.l2_hit    = 1'b0;
        bus.mem_rdata = 32'hCAFEF00D;
        push(2'b10, 32'hCAFEF00D);
        issue(1'b0, 32'hC0, 32'h0);
        run(6);
        chk("mem_c6_rd_en", 32'({bus.l2_rd_en, bus.mem_rd_en}), 32'h1);
        chk("mem_c6_addr", bus.mem_addr, 32'hC0);
        run(4);
        chk("mem_c10_rd_en", 32'(bus.mem_rd_en), 32'd1);
        chk("mem_c10_resp_valid", 32'(bus.resp_valid), 32'd0);
        run(1);
        chk("mem_c11_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("mem_c11_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("mem_c11_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en, bus.mem_wr_en}), 32'h6);
        chk("mem_c11_l2_wdata", bus.l2_wdata, 32'hCAFEF00D);
        run(2);
        chk("mem_c13_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en}), 32'h3);
        chk("mem_c13_ready", 32'(bus.req_ready), 32'd0);
        run(1);
        chk("mem_c14_wr_en", 32'({bus.l1_wr_en, bus.l2_wr_en}), 32'h0);
        chk("mem_c14_ready", 32'(bus.req_ready), 32'd1);

`ifdef CACHE_PERF_CNT_EN
        chk("perf_l1_hit", perf_l1_hit, 32'd2);
        chk("perf_l2_hit", perf_l2_hit, 32'd1);
        chk("perf_mem_rd", perf_mem_rd, 32'd1);
        chk("perf_wr", perf_wr, 32'd2);
`endif

        // Reset during the memory read: no response may follow
        issue(1'b0, 32'hC0, 32'h0);
        run(8);
        chk("rstmid_c8_mem_rd_en", 32'(bus.mem_rd_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_async_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rstmid_async_ready", 32'(bus.req_ready), 32'd1);
        run(2);
        rst = 1'b0;
        chk("rstmid_rel_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmid_rel_resp_valid", 32'(bus.resp_valid), 32'd0);
        run(12);
        chk("rstmid_quiet", 32'({bus.l1_rd_en, bus.l1_wr_en, bus.l2_rd_en, bus.l2_wr_en,
                                 bus.mem_rd_en, bus.mem_wr_en, bus.req_ready}), 32'h1);
`ifdef CACHE_PERF_CNT_EN
        chk("perf_cleared", perf_l1_hit | perf_l2_hit | perf_mem_rd | perf_wr, 32'd0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
